ps2_rx_fifo: RTL and testbench

Parametrised PS/2 device-to-host receiver with an integrated receive FIFO. Synchronises and deglitches PS2_CLK and PS2_DAT, deserialises 11-bit frames, and checks start, parity and stop bits. A watchdog resynchronises on stalled frames. Good bytes are queued in a show-ahead FIFO read by the CPU-side keyboard controller, so no scancodes are lost between polls.

---
 rtl/ps2_rx_fifo.sv | 219 +++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx_fifo
// Purpose  : PS/2 device-to-host receiver (filter, framing, watchdog) feeding
//            a show-ahead receive FIFO for the keyboard controller.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                              CLOCK_50,
  input  logic                              rst_n,
  input  logic                              PS2_CLK,
  input  logic                              PS2_DAT,
  input  logic                              rd_en,
  input  logic                              clear_overflow,
  output logic [7:0]                        rd_data,
  output logic                              empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              overflow,
  output logic                              err_parity,
  output logic                              err_frame,
  output logic                              err_timeout
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int c_WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_WD_W-1:0]  c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]         c_STOP    = 4'd10;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } state_t;

  // Input conditioning
  logic                  clk_meta_q, clk_meta_d;
  logic                  clk_sync_q, clk_sync_d;
  logic                  dat_meta_q, dat_meta_d;
  logic                  dat_sync_q, dat_sync_d;
  logic [FILTER_LEN-1:0] filt_hist_q, filt_hist_d;
  logic                  filt_clk_q, filt_clk_d;
  logic                  fall_q, fall_d;

  // Frame receiver
  state_t                state_q, state_d;
  logic [3:0]            bitcnt_q, bitcnt_d;
  logic [8:0]            shift_q, shift_d;
  logic [c_WD_W-1:0]     wd_cnt_q, wd_cnt_d;
  logic                  err_parity_q, err_parity_d;
  logic                  err_frame_q, err_frame_d;
  logic                  err_timeout_q, err_timeout_d;
  logic                  w_push;

  // FIFO
  logic [7:0]            mem_q [FIFO_DEPTH];
  logic [c_PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [c_CNT_W-1:0]    count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_wr;
  logic                  w_ovf_set;

  always_comb begin
    clk_meta_d  = PS2_CLK;
    clk_sync_d  = clk_meta_q;
    dat_meta_d  = PS2_DAT;
    dat_sync_d  = dat_meta_q;
    filt_hist_d = {filt_hist_q[FILTER_LEN-2:0], clk_sync_q};
    filt_clk_d  = filt_clk_q;
    if (&filt_hist_q) begin
      filt_clk_d = 1'b1;
    end else if (~|filt_hist_q) begin
      filt_clk_d = 1'b0;
    end
    fall_d = filt_clk_q & ~filt_clk_d;
  end

  // Frame FSM; fall_q marks the cycle in which dat_sync_q is the bit value.
  always_comb begin
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    shift_d       = shift_q;
    wd_cnt_d      = wd_cnt_q;
    err_parity_d  = 1'b0;
    err_frame_d   = 1'b0;
    err_timeout_d = 1'b0;
    w_push        = 1'b0;
    case (state_q)
      S_IDLE: begin
        wd_cnt_d = '0;
        if (fall_q && !dat_sync_q) begin
          state_d  = S_RECV;
          bitcnt_d = 4'd1;
          shift_d  = '0;
        end
      end
      S_RECV: begin
        if (fall_q) begin
          wd_cnt_d = '0;
          if (bitcnt_q == c_STOP) begin
            state_d  = S_IDLE;
            bitcnt_d = '0;
            if (!dat_sync_q) begin
              err_frame_d = 1'b1;
            end else if (!(^shift_q)) begin
              err_parity_d = 1'b1;
            end else begin
              w_push = 1'b1;
            end
          end else begin
            // After nine shifts shift_q = {parity, D7..D0}.
            shift_d  = {dat_sync_q, shift_q[8:1]};
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end else if (wd_cnt_q == c_WD_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
          bitcnt_d      = '0;
          shift_d       = '0;
          wd_cnt_d      = '0;
        end else begin
          wd_cnt_d = wd_cnt_q + c_WD_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A push into a full FIFO still succeeds when a pop frees a slot that cycle.
  always_comb begin
    w_pop     = rd_en && (count_q != '0);
    w_full    = (count_q == c_FULL);
    w_wr      = w_push && (!w_full || w_pop);
    w_ovf_set = w_push && w_full && !w_pop;
    wr_ptr_d  = w_wr  ? wr_ptr_q + c_PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = w_pop ? rd_ptr_q + c_PTR_W'(1) : rd_ptr_q;
    count_d   = count_q;
    case ({w_wr, w_pop})
      2'b10:   count_d = count_q + c_CNT_W'(1);
      2'b01:   count_d = count_q - c_CNT_W'(1);
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (w_ovf_set) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q    <= 1'b1;
      clk_sync_q    <= 1'b1;
      dat_meta_q    <= 1'b1;
      dat_sync_q    <= 1'b1;
      filt_hist_q   <= '1;
      filt_clk_q    <= 1'b1;
      fall_q        <= 1'b0;
      state_q       <= S_IDLE;
      bitcnt_q      <= '0;
      shift_q       <= '0;
      wd_cnt_q      <= '0;
      err_parity_q  <= 1'b0;
      err_frame_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
    end else begin
      clk_meta_q    <= clk_meta_d;
      clk_sync_q    <= clk_sync_d;
      dat_meta_q    <= dat_meta_d;
      dat_sync_q    <= dat_sync_d;
      filt_hist_q   <= filt_hist_d;
      filt_clk_q    <= filt_clk_d;
      fall_q        <= fall_d;
      state_q       <= state_d;
      bitcnt_q      <= bitcnt_d;
      shift_q       <= shift_d;
      wd_cnt_q      <= wd_cnt_d;
      err_parity_q  <= err_parity_d;
      err_frame_q   <= err_frame_d;
      err_timeout_q <= err_timeout_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (w_wr) begin
      mem_q[wr_ptr_q] <= shift_q[7:0];
    end
  end

  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign empty       = (count_q == '0);
  assign rd_data     = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign err_parity  = err_parity_q;
  assign err_frame   = err_frame_q;
  assign err_timeout = err_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// Testbench for ps2_rx_fifo: randomized PS/2 frames against a queue-based
// reference model, with a monitor scoreboarding error pulses and FIFO reads.
module tb_ps2_rx_fifo;

  localparam int TB_DEPTH = 16;
  localparam int TB_TO    = 1000;
  localparam int TB_CW    = $clog2(TB_DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ps2_clk = 1'b1;
  logic             ps2_dat = 1'b1;
  logic             rd_en = 1'b0;
  logic             clear_overflow = 1'b0;
  logic [7:0]       rd_data;
  logic             empty;
  logic [TB_CW-1:0] count;
  logic             overflow;
  logic             err_parity;
  logic             err_frame;
  logic             err_timeout;

  ps2_rx_fifo #(
    .FILTER_LEN     (8),
    .FIFO_DEPTH     (TB_DEPTH),
    .TIMEOUT_CYCLES (TB_TO)
  ) dut (
    .CLOCK_50       (clk),
    .rst_n          (rst_n),
    .PS2_CLK        (ps2_clk),
    .PS2_DAT        (ps2_dat),
    .rd_en          (rd_en),
    .clear_overflow (clear_overflow),
    .rd_data        (rd_data),
    .empty          (empty),
    .count          (count),
    .overflow       (overflow),
    .err_parity     (err_parity),
    .err_frame      (err_frame),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hp = 30;

  // Reference model: queue of bytes the FIFO should hold, sticky overflow,
  // and the ordered list of error events expected (1 parity, 2 frame, 3 timeout).
  logic [7:0] model[$];
  bit         model_ovf = 1'b0;
  int         exp_err[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int act_c, exp_c;
  logic [31:0] exp_b;

  always @(negedge clk) begin
    if (rst_n) begin
      if (err_parity || err_frame || err_timeout) begin
        act_c = err_frame ? 2 : (err_parity ? 1 : 3);
        exp_c = (exp_err.size() > 0) ? exp_err.pop_front() : 0;
        chk("err_event", act_c, exp_c);
        chk("err_onehot", 32'(err_parity) + 32'(err_frame) + 32'(err_timeout), 1);
      end
      if (rd_en && !empty) begin
        exp_b = (model.size() > 0) ? {24'h0, model.pop_front()} : 32'hDEAD;
        chk("rd_data", {24'h0, rd_data}, exp_b);
      end
    end
  end

  task automatic ps2_bit(input logic v);
    ps2_dat = v;
    tick(hp);
    ps2_clk = 1'b0;
    tick(hp);
    ps2_clk = 1'b1;
  endtask

  task automatic settle(input string tag);
    tick(20);
    chk({tag, "_count"}, 32'(count), model.size());
    chk({tag, "_empty"}, 32'(empty), (model.size() == 0) ? 1 : 0);
    chk({tag, "_ovf"}, 32'(overflow), 32'(model_ovf));
    if (model.size() > 0) chk({tag, "_head"}, 32'(rd_data), 32'(model[0]));
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad parity and stop
  task automatic send_frame(input logic [7:0] b, input int kind);
    logic p, stop;
    p    = ~^b;
    if (kind == 1 || kind == 3) p = ~p;
    stop = (kind >= 2) ? 1'b0 : 1'b1;
    if (kind == 0) begin
      if (model.size() < TB_DEPTH) model.push_back(b);
      else model_ovf = 1'b1;
    end else begin
      exp_err.push_back((kind == 1) ? 1 : 2);
    end
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(stop);
    ps2_dat = 1'b1;
    tick(2 * hp);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    logic [8:0] bits;
    bits = {b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
  endtask

  task automatic drain(input string tag);
    int n;
    n = model.size();
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      tick(1);
    end
    rd_en = 1'b0;
    tick(2);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_left"}, model.size(), 0);
    model.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    model.delete();
    model_ovf = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(20);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tick(3);
    chk("init_errs", {29'h0, err_parity, err_frame, err_timeout}, 0);
    do_reset();

    send_frame(8'h1C, 0);
    settle("good1c");
    drain("drain1c");

    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    tick(1);
    chk("rd_empty_count", 32'(count), 0);

    send_frame(8'h1C, 1);
    settle("par1c");
    send_frame(8'hF0, 0);
    settle("goodf0");
    drain("drainf0");

    send_frame(8'h5A, 2);
    settle("stop5a");
    send_frame(8'h5A, 3);
    settle("both5a");

    exp_err.push_back(3);
    send_partial(8'hA5, 5);
    ps2_dat = 1'b1;
    tick(TB_TO * 12 / 10 + 100);
    chk("timeout_drained", exp_err.size(), 0);
    send_frame(8'hF0, 0);
    settle("after_to");
    drain("drain_to");

    ps2_dat = 1'b0;
    repeat (5) begin
      ps2_clk = 1'b0;
      tick(3);
      ps2_clk = 1'b1;
      tick(15);
    end
    ps2_dat = 1'b1;
    tick(TB_TO + 100);
    settle("glitch");
    send_frame(8'h3C, 0);
    settle("after_glitch");
    drain("drain_glitch");

    for (int i = 1; i <= 17; i++) send_frame(8'(i), 0);
    settle("full");
    drain("drain_full");
    chk("ovf_sticky", 32'(overflow), 1);
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    model_ovf = 1'b0;
    tick(1);
    chk("ovf_cleared", 32'(overflow), 0);

    send_partial(8'h77, 6);
    do_reset();
    send_frame(8'h1C, 0);
    settle("rst_mid");
    send_frame(8'h22, 0);
    send_frame(8'h33, 0);
    settle("pre_rst3");
    do_reset();
    send_frame(8'h1C, 0);
    settle("rst_cnt3");
    drain("drain_rst");

    for (int i = 0; i < 20; i++) begin
      int r;
      r  = $urandom_range(0, 9);
      hp = $urandom_range(20, 40);
      send_frame(8'($urandom_range(0, 255)), (r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3);
      settle("rand");
      if (model.size() > 10 || $urandom_range(0, 3) == 0) drain("rand_drain");
    end
    drain("final_drain");
    tick(10);
    chk("pending_err", exp_err.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
